// File: rtl/mlu_pkg.sv
// mlu_pkg: shared types and elaboration helpers for the iterative multiplier.
//   mlu_state_t    : controller states
//   iter_count()   : number of shift-add iterations for a WIDTH/BPC pair
//   cnt_width()    : bit width of the iteration counter
//   params_legal() : WIDTH/BPC legality, evaluated at elaboration
package mlu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mlu_state_t;

    function automatic int iter_count(int width, int bpc);
        return width / bpc;
    endfunction

    // A single-iteration configuration still needs a 1-bit counter.
    function automatic int cnt_width(int width, int bpc);
        int n;
        n = width / bpc;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_legal(int width, int bpc);
        return (width >= 8) && (width % 2 == 0) &&
               (bpc == 1 || bpc == 2 || bpc == 4 || bpc == 8) &&
               (width % bpc == 0);
    endfunction

endpackage

// File: rtl/mlu_iter_if.sv
// mlu_iter_if: request/response bundle between the execute stage and mlu_iter.
//   master : start, signed_i, op_a, op_b, flush out; ready, busy, valid, result in
//   slave  : the multiplier side of the same signals
interface mlu_iter_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_i;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic                   flush;
    logic                   ready;
    logic                   busy;
    logic                   valid;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, signed_i, op_a, op_b, flush,
        input  ready, busy, valid, result
    );

    modport slave (
        input  start, signed_i, op_a, op_b, flush,
        output ready, busy, valid, result
    );
endinterface

// File: rtl/mlu_chunk_pp.sv
// mlu_chunk_pp: combinational WIDTH x BPC partial product.
//   mag_a : unsigned multiplicand magnitude
//   chunk : current BPC-bit slice of the multiplier magnitude
//   pp    : unshifted partial product, WIDTH+BPC bits
module mlu_chunk_pp #(
    parameter int WIDTH = 32,
    parameter int BPC   = 2
) (
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [BPC-1:0]       chunk,
    output logic [WIDTH+BPC-1:0] pp
);
    assign pp = (WIDTH+BPC)'(mag_a) * (WIDTH+BPC)'(chunk);
endmodule

// File: rtl/mlu_iter.sv
// mlu_iter: iterative signed/unsigned multiplier, BPC multiplier bits per cycle.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : start/signed_i/op_a/op_b/flush in; ready/busy/valid/result out
//
// state | meaning
// IDLE  | waiting for start; ready=1
// BUSY  | shift-add iterations in progress; busy=1
// DONE  | product written to result this cycle; valid=1, ready=1
module mlu_iter
    import mlu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    mlu_iter_if.slave  bus
);
    localparam int N  = iter_count(WIDTH, BPC);
    localparam int CW = cnt_width(WIDTH, BPC);

    if (!params_legal(WIDTH, BPC)) begin : g_bad_params
        $error("mlu_iter: illegal WIDTH/BPC combination");
    end

    mlu_state_t            state_q;
    logic                  ready_q, busy_q, valid_q;
    logic [CW-1:0]         cnt_q;
    logic [WIDTH-1:0]      mag_a_q;
    logic [WIDTH-1:0]      mag_b_q;
    logic                  neg_q;
    logic [2*WIDTH-1:0]    acc_q;
    logic [2*WIDTH-1:0]    result_q;

    logic [WIDTH-1:0]      mag_a_in, mag_b_in;
    logic                  neg_in;
    logic [WIDTH+BPC-1:0]  pp;
    logic [2*WIDTH-1:0]    pp_shift, acc_next, prod_final;

    // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude.
    assign mag_a_in = (bus.signed_i & bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign mag_b_in = (bus.signed_i & bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    assign neg_in   = bus.signed_i & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);

    // mag_b_q shifts right each iteration, so its low BPC bits are always chunk i.
    mlu_chunk_pp #(.WIDTH(WIDTH), .BPC(BPC)) u_pp (
        .mag_a (mag_a_q),
        .chunk (mag_b_q[BPC-1:0]),
        .pp    (pp)
    );

    assign pp_shift   = (2*WIDTH)'(pp) << (int'(cnt_q) * BPC);
    assign acc_next   = acc_q + pp_shift;
    assign prod_final = neg_q ? -acc_next : acc_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            // Abort wins over everything, including a simultaneous start; result is kept.
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= BUSY;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        mag_a_q <= mag_a_in;
                        mag_b_q <= mag_b_in;
                        neg_q   <= neg_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    acc_q   <= acc_next;
                    cnt_q   <= cnt_q + 1'b1;
                    mag_b_q <= mag_b_q >> BPC;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q  <= DONE;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                        result_q <= prod_final;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mlu_iter.sv
// tb_mlu_iter: scoreboard bench for mlu_iter. Directed cases on a WIDTH=32/BPC=2
// instance, then a random sweep over six other WIDTH/BPC instances in parallel.
module tb_mlu_iter;

    localparam int N0 = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit sweep_go = 1'b0;
    int sweep_done = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference product via 64-bit arithmetic, truncated to 2*w bits.
    function automatic logic [63:0] ref_prod(int w, bit s, logic [63:0] a, logic [63:0] b);
        logic [63:0] p;
        if (s && a[w-1]) a = a | (~64'd0 << w);
        if (s && b[w-1]) b = b | (~64'd0 << w);
        p = a * b;
        if (2*w < 64) p = p & ((64'd1 << (2*w)) - 64'd1);
        return p;
    endfunction

    // ---------------- main instance: WIDTH=32, BPC=2 ----------------
    mlu_iter_if #(.WIDTH(32)) bus0 ();
    mlu_iter #(.WIDTH(32), .BPC(2)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    logic [63:0] q0[$];

    always @(negedge clk) begin
        if (bus0.valid) begin
            if (q0.size() == 0) check("spurious_valid", 64'(bus0.valid), 64'd0);
            else check("product", bus0.result, q0.pop_front());
        end
    end

    // Call at a negedge with ready=1; returns #1 after the accepting edge.
    task automatic issue(bit s, logic [31:0] a, logic [31:0] b, logic [63:0] exp);
        bus0.start    = 1'b1;
        bus0.signed_i = s;
        bus0.op_a     = a;
        bus0.op_b     = b;
        q0.push_back(exp);
        @(posedge clk);
        #1;
        bus0.start    = 1'b0;
        bus0.op_a     = $urandom;
        bus0.op_b     = $urandom;
        bus0.signed_i = 1'($urandom);
    endtask

    // Counts edges from the accepting edge (counted as 1) until valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus0.valid) return;
            @(posedge clk);
            lat++;
        end
        check("valid_timeout", 64'(bus0.valid), 64'd1);
    endtask

    task automatic count_valids(int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus0.valid) seen++;
        end
    endtask

    initial begin
        int lat, seen;
        logic [31:0] a, b;
        bus0.start = 0; bus0.signed_i = 0; bus0.op_a = 0; bus0.op_b = 0; bus0.flush = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready",  64'(bus0.ready), 64'd1);
        check("reset_busy",   64'(bus0.busy),  64'd0);
        check("reset_valid",  64'(bus0.valid), 64'd0);
        check("reset_result", bus0.result,     64'd0);
        resetn = 1'b1;
        @(negedge clk);

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_valid(lat);
        check("latency_umax", 64'(lat), 64'd17);
        @(negedge clk);
        check("valid_one_cycle", 64'(bus0.valid), 64'd0);

        issue(1'b1, 32'hFFFF_FFF9, 32'd0, 64'd0);
        wait_valid(lat);
        @(negedge clk);
        issue(1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        wait_valid(lat);
        @(negedge clk);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        wait_valid(lat);
        @(negedge clk);

        // flush sampled at the edge ending cycle 8
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, ref_prod(32, 1'b0, 64'h1234_5678, 64'h9ABC_DEF0));
        repeat (7) @(posedge clk);
        @(negedge clk);
        bus0.flush = 1'b1;
        void'(q0.pop_back());
        @(posedge clk);
        #1 bus0.flush = 1'b0;
        @(negedge clk);
        check("flush_ready",  64'(bus0.ready), 64'd1);
        check("flush_busy",   64'(bus0.busy),  64'd0);
        check("flush_valid",  64'(bus0.valid), 64'd0);
        check("flush_result", bus0.result,     64'h4000_0000_0000_0000);
        count_valids(N0 + 4, seen);
        check("flush_no_valid", 64'(seen), 64'd0);

        // flush together with start
        bus0.start = 1'b1; bus0.flush = 1'b1; bus0.signed_i = 1'b0;
        bus0.op_a = 32'd3; bus0.op_b = 32'd4;
        @(posedge clk);
        #1 bus0.start = 1'b0; bus0.flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy",  64'(bus0.busy),  64'd0);
        check("flush_start_ready", 64'(bus0.ready), 64'd1);
        count_valids(N0 + 4, seen);
        check("flush_start_no_valid", 64'(seen), 64'd0);

        // start held through BUSY with changing operands
        a = $urandom; b = $urandom;
        issue(1'b1, a, b, ref_prod(32, 1'b1, 64'(a), 64'(b)));
        bus0.start = 1'b1;
        for (int i = 1; i < N0; i++) begin
            bus0.op_a = $urandom;
            bus0.op_b = $urandom;
            @(negedge clk);
            check("held_start_busy", 64'(bus0.busy), 64'd1);
            @(posedge clk);
            #1;
        end
        bus0.start = 1'b0;
        wait_valid(lat);
        check("held_start_latency", 64'(N0 - 1 + lat), 64'(N0 + 1));
        @(negedge clk);

        // back-to-back: second start in the DONE cycle
        a = $urandom; b = $urandom;
        issue(1'b0, a, b, ref_prod(32, 1'b0, 64'(a), 64'(b)));
        wait_valid(lat);
        a = $urandom; b = $urandom;
        issue(1'b1, a, b, ref_prod(32, 1'b1, 64'(a), 64'(b)));
        wait_valid(lat);
        check("b2b_latency", 64'(lat), 64'(N0 + 1));
        @(negedge clk);
        check("b2b_valid_drop", 64'(bus0.valid), 64'd0);

        // reset sampled at the edge ending cycle 5
        issue(1'b0, 32'd1000, 32'd1000, 64'd1_000_000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        q0.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("midreset_ready",  64'(bus0.ready), 64'd1);
        check("midreset_busy",   64'(bus0.busy),  64'd0);
        check("midreset_valid",  64'(bus0.valid), 64'd0);
        check("midreset_result", bus0.result,     64'd0);
        count_valids(N0 + 4, seen);
        check("midreset_no_valid", 64'(seen), 64'd0);
        issue(1'b1, 32'hFFFF_FF00, 32'd77, ref_prod(32, 1'b1, 64'hFFFF_FF00, 64'd77));
        wait_valid(lat);
        check("post_reset_latency", 64'(lat), 64'(N0 + 1));
        @(negedge clk);

        sweep_go = 1'b1;
        for (int i = 0; i < 80000 && sweep_done < 6; i++) @(posedge clk);
        check("sweep_finished", 64'(sweep_done), 64'd6);
        check("main_queue_empty", 64'(q0.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- parameter sweep ----------------
    localparam int SW_W [6] = '{32, 32, 32, 16, 16, 16};
    localparam int SW_B [6] = '{1, 4, 8, 1, 4, 8};

    for (genvar g = 0; g < 6; g++) begin : g_sweep
        localparam int W  = SW_W[g];
        localparam int B  = SW_B[g];
        localparam int NI = W / B;

        mlu_iter_if #(.WIDTH(W)) bus_s ();
        mlu_iter #(.WIDTH(W), .BPC(B)) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (bus_s)
        );

        logic [63:0] q[$];

        always @(negedge clk) begin
            if (bus_s.valid) begin
                if (q.size() == 0) check("sweep_spurious_valid", 64'(bus_s.valid), 64'd0);
                else check("sweep_product", 64'(bus_s.result), q.pop_front());
            end
        end

        initial begin
            logic [W-1:0] a, b;
            bit s, got;
            int lat;
            bus_s.start = 0; bus_s.signed_i = 0; bus_s.op_a = 0; bus_s.op_b = 0; bus_s.flush = 0;
            wait (sweep_go);
            @(negedge clk);
            // each op starts in the DONE cycle of the previous one
            for (int k = 0; k < 1000; k++) begin
                a = W'($urandom);
                b = W'($urandom);
                s = 1'($urandom_range(0, 1));
                if (k % 97 == 0) a = {1'b1, {(W-1){1'b0}}};
                if (k % 89 == 0) b = '1;
                if (k % 83 == 0) b = '0;
                bus_s.start = 1'b1; bus_s.signed_i = s; bus_s.op_a = a; bus_s.op_b = b;
                q.push_back(ref_prod(W, s, 64'(a), 64'(b)));
                @(posedge clk);
                #1;
                bus_s.start = 1'b0;
                bus_s.op_a  = W'($urandom);
                bus_s.op_b  = W'($urandom);
                lat = 1;
                got = 1'b0;
                for (int i = 0; i < 300 && !got; i++) begin
                    @(negedge clk);
                    if (bus_s.valid) got = 1'b1;
                    else begin
                        @(posedge clk);
                        lat++;
                    end
                end
                if (!got) check("sweep_timeout", 64'(bus_s.valid), 64'd1);
                else check("sweep_latency", 64'(lat), 64'(NI + 1));
            end
            @(negedge clk);
            sweep_done++;
        end
    end

endmodule

// File: doc/mlu_iter.md
# mlu_iter

Parametrised iterative multiplier for the CPU execute stage. It computes a full 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, retiring BPC multiplier bits per cycle through a registered shift-add datapath. It uses a start/ready/valid handshake and a flush input so the pipeline can stall on it and cancel it on exceptions.

## Interface
- WIDTH, 32: operand width; must be even and ≥ 8.
- BPC, 2: multiplier bits retired per cycle; one of 1, 2, 4, 8; must divide WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted when start & ready & !flush.
- signed_i  in  1  1 = two's-complement operands; sampled with start.
- op_a  in  WIDTH  multiplicand; sampled with start.
- op_b  in  WIDTH  multiplier; sampled with start.
- flush  in  1  abort any operation in flight.
- ready  out  1  can accept start this cycle.
- busy  out  1  operation in progress.
- valid  out  1  one-cycle pulse; result is the new product.
- result  out  2·WIDTH  product; held until next completion.

## Operation
- N = WIDTH/BPC iterations. Cycle counter is clog2(N) bits wide.
- States:
  - IDLE: ready=1, busy=0, valid=0.
  - BUSY: ready=0, busy=1, valid=0.
  - DONE: ready=1, busy=0, valid=1.
- Transitions:
  - IDLE→BUSY on an accepted start.
  - BUSY→DONE on the edge that completes iteration N−1.
  - DONE→BUSY on an accepted start; otherwise DONE→IDLE.
  - Any state→IDLE when flush=1.
- On accept:
  - mag_a = (signed_i & op_a[W−1]) ? −op_a : op_a, taken as a W-bit unsigned value. mag_b is formed the same way from op_b.
  - neg = signed_i & (op_a[W−1] ^ op_b[W−1]).
  - The 2W-bit accumulator is cleared and the counter is zeroed.
- Each BUSY edge i: acc += (mag_a × mag_b[i·BPC +: BPC]) << (i·BPC). Then i increments.
- Final edge: result ← neg ? −acc_final : acc_final, in 2W-bit two's complement.
- Width rules:
  - Magnitude of −2^(W−1) is 2^(W−1), which fits W unsigned bits.
  - Every intermediate sum fits 2W bits; no overflow case exists.
  - A zero product with neg=1 gives 0.
- Boundary cases:
  - start while BUSY is ignored and not queued.
  - flush together with start: flush wins and start is dropped.
  - flush never changes result and never pulses valid.
  - Operands may change after acceptance; the captured copies are used.
- Reset (resetn=0 at an edge), including mid-operation:
  - State IDLE, ready=1, busy=0, valid=0.
  - result=0, accumulator=0, counter=0.

## Timing
- Latency: start accepted in cycle 0, BUSY in cycles 1..N, valid=1 in cycle N+1. With WIDTH=32 and BPC=2, valid is in cycle 17.
- Throughput: one product per N+1 cycles. A new start in the DONE cycle begins BUSY in the next cycle.
- ready, busy and valid are decoded purely from registered state; no combinational path from inputs to outputs.
- Flush in cycle k gives ready=1 in cycle k+1.
- Critical path is one W×BPC partial product plus one 2W-bit add.

## Structure
- Package mlu_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Function for iteration count and counter width from WIDTH/BPC.
  - Parameter legality check.
- Sub-module mlu_chunk_pp: combinational W×BPC partial-product generator, fed by mag_a and the current multiplier chunk. Output width W+BPC, shifted by the top level.
- Top level holds the FSM, counter, operand/sign registers, accumulator and the result negation.

## Test plan
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF, W=32/BPC=2 → valid exactly in cycle 17, result 0xFFFFFFFE00000001, one-cycle valid.
- Signed −3 × 5 → 0xFFFFFFFFFFFFFFF1. Signed 0x80000000 × 0x80000000 → 0x4000000000000000. Signed −7 × 0 → 0.
- Flush in cycle 8 of an operation → no valid pulse, ready=1 in cycle 9, result keeps its prior value. Flush and start together → start dropped.
- start held high during BUSY with changing op_a/op_b → ignored. A start in the DONE cycle → second product valid exactly N+1 cycles later and correct.
- resetn low in cycle 5 → next cycle IDLE, result=0, no valid. A fresh op then completes normally.
- Parameter sweep with BPC ∈ {1,4,8} at W=32 and W=16 → latency N+1. 1000 random signed and unsigned operand pairs each, matching a reference product.
